syscall_unit: RTL and testbench
===============================

SYSCALL_UNIT -- requirements
Module: syscall_unit

Interface
REQ-001 SHALL have parameter HEAP_BASE, default 32'h00000080: initial heap pointer.
REQ-002 SHALL have parameter HEAP_LIMIT, default 32'h00000400: first byte beyond the heap.
REQ-003 SHALL have parameter MAX_STR_LEN, default 64: maximum characters emitted per print-string.
REQ-004 Ports, in this order:
- clk  in  1  clock, rising edge.
- reset  in  1  reset; synchronous, active-high.
- sys_req  in  1  syscall present; held high while stall=1.
- v0  in  32  service code.
- a0  in  32  argument.
- stall  out  1  freeze PC and pipeline.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  write register.
- rf_wdata  out  32  write data.
- mem_ren  out  1  byte read request.
- mem_addr  out  32  byte address.
- mem_rbyte  in  8  read byte, valid one cycle after mem_ren.
- out_valid  out  1  character valid.
- out_data  out  8  ASCII character.
- out_ready  in  1  sink accepts.
- halt  out  1  sticky exit flag.
- err  out  1  one-cycle error pulse.

Function
REQ-005 States SHALL be IDLE, HEX, CHR, STR_REQ, STR_WAIT, STR_OUT, DONE, HALT.
REQ-006 In IDLE with sys_req=1, the unit SHALL decode v0:
- 1 -> HEX.
- 4 -> STR_REQ.
- 9 -> sbrk.
- 10 -> HALT.
- 11 -> CHR.
- other -> err=1 for that cycle, stay in IDLE, stall=0.
REQ-007 stall SHALL be combinational: 1 when (IDLE and sys_req and v0 in {1,4,11}), or in HEX, CHR, STR_*; 0 in IDLE otherwise, in DONE, and in HALT.
REQ-008 sbrk SHALL complete in the IDLE cycle with stall=0:
- request rounded up to a multiple of 4: rq=(a0+3)&~3.
- rf_we=1, rf_waddr=2, rf_wdata=old heap pointer.
- heap pointer += rq at the clock edge.
REQ-009 rf_we SHALL be 0 in every cycle other than an sbrk cycle.
REQ-010 HEX SHALL emit 8 lowercase hex ASCII digits of a0, most significant nibble first, via a 3-bit digit counter; exit to DONE after the 8th accepted digit.
REQ-011 CHR SHALL emit a0[7:0] once, then go to DONE.
REQ-012 String walk:
- STR_REQ: mem_ren=1, mem_addr=ptr; ptr is initialised to a0.
- STR_WAIT: capture mem_rbyte. Byte 0 -> DONE; otherwise -> STR_OUT.
- STR_OUT: emit the byte; on acceptance ptr+1, count+1. count==MAX_STR_LEN -> DONE; else -> STR_REQ.
REQ-013 Output handshake: a transfer occurs when out_valid and out_ready are both 1. out_data SHALL remain stable while out_valid=1 and out_ready=0. out_valid SHALL never drop without a transfer.
REQ-014 DONE SHALL last exactly one cycle with stall=0, ignore sys_req, then return to IDLE; this lets the held syscall retire once.
REQ-015 HALT SHALL set halt=1 from the next cycle; it is absorbing until reset and ignores sys_req.
REQ-016 mem_ren SHALL be 1 only in STR_REQ.
REQ-017 ptr arithmetic SHALL be 32-bit modulo and wrap from 0xFFFFFFFF to 0.

Reset
REQ-018 On reset, including mid-operation, the unit SHALL apply the following at the next edge:
- state=IDLE.
- heap pointer=HEAP_BASE.
- counters=0.
- halt=0, err=0, out_valid=0, mem_ren=0, rf_we=0, stall=0.
- out_data=0, rf_waddr=0, rf_wdata=0, mem_addr=0.
REQ-019 A transfer pending at reset SHALL be abandoned and not replayed.

Configuration
REQ-020 With macro SYSCALL_HEAP_CHECK_EN defined, if old pointer + rq > HEAP_LIMIT or the addition overflows, sbrk SHALL:
- write 32'hFFFFFFFF to register 2;
- leave the heap pointer unchanged;
- pulse err=1.
REQ-021 Without SYSCALL_HEAP_CHECK_EN, the heap pointer SHALL advance unconditionally modulo 2^32, and err SHALL pulse only for unknown codes.

Verification
REQ-022 sbrk: reset, then v0=9, a0=5 -> same cycle rf_we=1, rf_waddr=2, rf_wdata=0x80, stall=0; second sbrk a0=4 returns 0x88.
REQ-023 Limit check (macro on): v0=9, a0=0x400 after reset -> rf_wdata=0xFFFFFFFF, err=1; next sbrk a0=4 returns 0x80. Macro off: same stimulus returns 0x80, then 0x480.
REQ-024 Print int: v0=1, a0=0xDEADBEEF, out_ready=1 -> chars "deadbeef" on 8 consecutive cycles; stall high throughout, then one DONE cycle with stall=0.
REQ-025 Print string with backpressure: memory at 0x10 holds "Hi\0", v0=4, a0=0x10, out_ready low for 3 cycles on 'H' -> 'H' held stable, then 'i', then DONE; mem_addr sequence 0x10, 0x11, 0x12.
REQ-026 String cap: MAX_STR_LEN=4, memory holds "ABCDEFG" with no terminator -> exactly "ABCD" emitted, then DONE.
REQ-027 Exit and reset: v0=10 -> halt=1 next cycle and stays 1 under further sys_req; reset asserted mid-print-string -> state IDLE, out_valid=0, halt=0, heap=0x80.

Source files
------------

// File: rtl/syscall_unit.sv
// Syscall service unit: print int/char/string, sbrk heap allocation and exit.
// Optional heap-limit checking on sbrk is enabled by defining SYSCALL_HEAP_CHECK_EN.
module syscall_unit #(
    parameter logic [31:0] HEAP_BASE   = 32'h0000_0080,
    parameter logic [31:0] HEAP_LIMIT  = 32'h0000_0400,
    parameter int          MAX_STR_LEN = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sys_req,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic        stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        mem_ren,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rbyte,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        halt,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, HEX, CHR, STR_REQ, STR_WAIT, STR_OUT, DONE, HALT
    } state_t;

    localparam logic [31:0] STR_CAP = 32'(MAX_STR_LEN);

    state_t      state_r, state_next_s;
    logic [31:0] heap_r, arg_r, ptr_r, cnt_r;
    logic [2:0]  dig_r;
    logic [7:0]  byte_r;
    logic [31:0] rq_s, heap_new_s;
    logic        heap_fail_s, heap_we_s, req_s;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) return 8'h30 + {4'h0, nib};
        else             return 8'h57 + {4'h0, nib};
    endfunction

    assign req_s = sys_req & ~reset;
    assign rq_s  = (a0 + 32'd3) & ~32'd3;

`ifdef SYSCALL_HEAP_CHECK_EN
    logic [32:0] heap_sum_s;
    assign heap_sum_s  = {1'b0, heap_r} + {1'b0, rq_s};
    assign heap_fail_s = heap_sum_s[32] | (heap_sum_s[31:0] > HEAP_LIMIT);
    assign heap_new_s  = heap_sum_s[31:0];
`else
    assign heap_fail_s = 1'b0;
    assign heap_new_s  = heap_r + rq_s;
`endif

    assign halt = (state_r == HALT);

    // Next-state decode and all combinational handshake/register-file outputs
    always_comb begin
        state_next_s = state_r;
        stall        = 1'b0;
        rf_we        = 1'b0;
        rf_waddr     = 5'd0;
        rf_wdata     = 32'd0;
        mem_ren      = 1'b0;
        mem_addr     = 32'd0;
        out_valid    = 1'b0;
        out_data     = 8'd0;
        err          = 1'b0;
        heap_we_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    case (v0)
                        32'd1: begin
                            state_next_s = HEX;
                            stall        = 1'b1;
                        end
                        32'd4: begin
                            state_next_s = STR_REQ;
                            stall        = 1'b1;
                        end
                        32'd9: begin
                            rf_we     = 1'b1;
                            rf_waddr  = 5'd2;
                            rf_wdata  = heap_fail_s ? 32'hFFFF_FFFF : heap_r;
                            err       = heap_fail_s;
                            heap_we_s = ~heap_fail_s;
                        end
                        32'd10: state_next_s = HALT;
                        32'd11: begin
                            state_next_s = CHR;
                            stall        = 1'b1;
                        end
                        default: err = 1'b1;
                    endcase
                end else begin
                    state_next_s = IDLE;
                end
            end
            HEX: begin
                stall     = 1'b1;
                out_valid = 1'b1;
                out_data  = hex_char(arg_r[{~dig_r, 2'b00} +: 4]);
                if (out_ready && (dig_r == 3'd7)) state_next_s = DONE;
                else                              state_next_s = HEX;
            end
            CHR: begin
                stall     = 1'b1;
                out_valid = 1'b1;
                out_data  = arg_r[7:0];
                if (out_ready) state_next_s = DONE;
                else           state_next_s = CHR;
            end
            STR_REQ: begin
                stall        = 1'b1;
                mem_ren      = 1'b1;
                mem_addr     = ptr_r;
                state_next_s = STR_WAIT;
            end
            STR_WAIT: begin
                stall        = 1'b1;
                state_next_s = (mem_rbyte == 8'd0) ? DONE : STR_OUT;
            end
            STR_OUT: begin
                stall     = 1'b1;
                out_valid = 1'b1;
                out_data  = byte_r;
                if (out_ready) state_next_s = ((cnt_r + 32'd1) == STR_CAP) ? DONE : STR_REQ;
                else           state_next_s = STR_OUT;
            end
            DONE:    state_next_s = IDLE;
            HALT:    state_next_s = HALT;
            default: state_next_s = IDLE;
        endcase
    end

    // State, heap pointer and walk counters; operands latch while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            heap_r  <= HEAP_BASE;
            arg_r   <= 32'd0;
            ptr_r   <= 32'd0;
            cnt_r   <= 32'd0;
            dig_r   <= 3'd0;
            byte_r  <= 8'd0;
        end else begin
            state_r <= state_next_s;
            if (heap_we_s) heap_r <= heap_new_s;
            case (state_r)
                IDLE: begin
                    arg_r <= a0;
                    ptr_r <= a0;
                    cnt_r <= 32'd0;
                    dig_r <= 3'd0;
                end
                HEX:      if (out_ready) dig_r <= dig_r + 3'd1;
                STR_WAIT: byte_r <= mem_rbyte;
                STR_OUT: begin
                    if (out_ready) begin
                        ptr_r <= ptr_r + 32'd1;
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_syscall_unit.sv
// Directed self-checking bench for syscall_unit with a character/address scoreboard.
module tb_syscall_unit;

    logic        clk = 1'b0;
    logic        reset, sys_req, out_ready;
    logic [31:0] v0, a0;
    logic        stall, rf_we, mem_ren, out_valid, halt, err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, mem_addr;
    logic [7:0]  mem_rbyte = 8'd0;
    logic [7:0]  out_data;
    logic [7:0]  mem [256];

    logic [7:0]  exp_q[$];
    logic [31:0] exp_addr[$];
    int          total = 0;
    int          passed = 0;
    int          ncyc;

    syscall_unit #(.MAX_STR_LEN(4)) dut (
        .clk(clk), .reset(reset), .sys_req(sys_req), .v0(v0), .a0(a0),
        .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rbyte(mem_rbyte),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .halt(halt), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ren) mem_rbyte <= mem[mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; sys_req = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    // Runs a print service after its decode cycle until the one-cycle DONE.
    task automatic run_svc(input int hold, input int reads, output int cycles);
        int  hold_left = hold;
        int  nreads = 0;
        int  extra = 0;
        bit  done = 1'b0;
        cycles = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            out_ready = (hold_left > 0) ? 1'b0 : 1'b1;
            #1;
            cycles++;
            if (mem_ren) begin
                nreads++;
                if (exp_addr.size() > 0) chk("mem_addr", mem_addr, exp_addr.pop_front());
            end
            if (out_valid && !out_ready) begin
                hold_left--;
                if (exp_q.size() > 0) chk("held_char", {24'd0, out_data}, {24'd0, exp_q[0]});
            end else if (out_valid) begin
                if (exp_q.size() > 0) chk("char", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
                else extra++;
            end
            if (!stall) begin
                done = 1'b1;
                chk("done_out_valid", {31'd0, out_valid}, 32'd0);
                sys_req = 1'b0;
            end
        end
        chk("done_reached", {31'd0, done}, 32'd1);
        chk("chars_left", exp_q.size(), 32'd0);
        chk("chars_extra", extra, 32'd0);
        chk("read_count", nreads, reads);
        exp_q.delete();
        exp_addr.delete();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        mem[8'h10] = "H"; mem[8'h11] = "i"; mem[8'h12] = 8'd0;
        for (int i = 0; i < 7; i++) mem[8'h40 + i] = 8'h41 + 8'(i);
        mem[8'hFF] = "Z";
        reset = 1'b1; sys_req = 1'b0; out_ready = 1'b1; v0 = 32'd0; a0 = 32'd0;

        // Reset state
        do_reset();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_flags", {26'd0, rf_we, mem_ren, out_valid, halt, err, 1'b0}, 32'd0);
        chk("rst_data", {24'd0, out_data} | {27'd0, rf_waddr} | rf_wdata | mem_addr, 32'd0);

        // sbrk: 5 rounds up to 8
        @(negedge clk); sys_req = 1'b1; v0 = 32'd9; a0 = 32'd5; #1;
        chk("sbrk1_we", {31'd0, rf_we}, 32'd1);
        chk("sbrk1_waddr", {27'd0, rf_waddr}, 32'd2);
        chk("sbrk1_data", rf_wdata, 32'h80);
        chk("sbrk1_stall", {31'd0, stall}, 32'd0);
        @(negedge clk); a0 = 32'd4; #1;
        chk("sbrk2_data", rf_wdata, 32'h88);
        @(negedge clk); sys_req = 1'b0; #1;
        chk("idle_we", {31'd0, rf_we}, 32'd0);

        // Heap-limit behaviour depends on the build
        do_reset();
        @(negedge clk); sys_req = 1'b1; v0 = 32'd9; a0 = 32'h400; #1;
`ifdef SYSCALL_HEAP_CHECK_EN
        chk("lim_data", rf_wdata, 32'hFFFF_FFFF);
        chk("lim_err", {31'd0, err}, 32'd1);
        @(negedge clk); a0 = 32'd4; #1;
        chk("lim_next", rf_wdata, 32'h80);
`else
        chk("lim_data", rf_wdata, 32'h80);
        chk("lim_err", {31'd0, err}, 32'd0);
        @(negedge clk); a0 = 32'd4; #1;
        chk("lim_next", rf_wdata, 32'h480);
`endif
        @(negedge clk); sys_req = 1'b0;

        // Unknown service code
        @(negedge clk); sys_req = 1'b1; v0 = 32'd7; #1;
        chk("unk_err", {31'd0, err}, 32'd1);
        chk("unk_stall", {30'd0, stall, rf_we}, 32'd0);
        @(negedge clk); sys_req = 1'b0; #1;
        chk("unk_err_clr", {31'd0, err}, 32'd0);

        // Print int
        @(negedge clk); sys_req = 1'b1; v0 = 32'd1; a0 = 32'hDEAD_BEEF; #1;
        push_str("deadbeef");
        chk("hex_dec_stall", {31'd0, stall}, 32'd1);
        run_svc(0, 0, ncyc);
        chk("hex_cycles", ncyc, 32'd9);

        // Print char
        @(negedge clk); sys_req = 1'b1; v0 = 32'd11; a0 = 32'h0000_0141; #1;
        exp_q.push_back(8'h41);
        run_svc(0, 0, ncyc);
        chk("chr_cycles", ncyc, 32'd2);

        // Print string with backpressure on the first character
        @(negedge clk); sys_req = 1'b1; v0 = 32'd4; a0 = 32'h10; #1;
        push_str("Hi");
        exp_addr = '{32'h10, 32'h11, 32'h12};
        run_svc(3, 3, ncyc);

        // Length cap of 4 on an unterminated string
        @(negedge clk); sys_req = 1'b1; v0 = 32'd4; a0 = 32'h40; #1;
        push_str("ABCD");
        exp_addr = '{32'h40, 32'h41, 32'h42, 32'h43};
        run_svc(0, 4, ncyc);

        // Pointer wraps past 0xFFFFFFFF
        @(negedge clk); sys_req = 1'b1; v0 = 32'd4; a0 = 32'hFFFF_FFFF; #1;
        push_str("Z");
        exp_addr = '{32'hFFFF_FFFF, 32'h0};
        run_svc(0, 2, ncyc);

        // Reset in the middle of a stalled string print
        @(negedge clk); sys_req = 1'b1; v0 = 32'd9; a0 = 32'd16;
        @(negedge clk); v0 = 32'd4; a0 = 32'h40; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        #1;
        chk("mid_valid", {31'd0, out_valid}, 32'd1);
        do_reset();
        chk("mr_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_state", {29'd0, stall, mem_ren, halt}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("mr_no_replay", {31'd0, out_valid}, 32'd0);
        end
        @(negedge clk); sys_req = 1'b1; v0 = 32'd9; a0 = 32'd0; #1;
        chk("mr_heap", rf_wdata, 32'h80);

        // Exit is sticky until reset
        @(negedge clk); v0 = 32'd10; #1;
        chk("exit_dec_stall", {31'd0, stall}, 32'd0);
        chk("exit_dec_halt", {31'd0, halt}, 32'd0);
        @(negedge clk); v0 = 32'd1; #1;
        chk("halt_set", {31'd0, halt}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("halt_sticky", {29'd0, halt, stall, out_valid}, 32'd4);
        end
        do_reset();
        chk("halt_clr", {31'd0, halt}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
